// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - bus command, tag constants and in-flight entry shared by the memory responder
package mem_pkg;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'b00,
        BUS_LOAD  = 2'b01,
        BUS_STORE = 2'b10
    } bus_command_e;

    localparam int MEM_TAG_BITS = 4;
    localparam int NUM_MEM_TAGS = 15;

    typedef struct packed {
        logic                    valid;
        logic [MEM_TAG_BITS-1:0] tag;
        logic [63:0]             data;
    } inflight_t;

    // Tag 0 means "no tag", so the sequence runs 1..NUM_MEM_TAGS and wraps back to 1.
    function automatic logic [MEM_TAG_BITS-1:0] tag_incr(input logic [MEM_TAG_BITS-1:0] t);
        return (t == MEM_TAG_BITS'(NUM_MEM_TAGS)) ? MEM_TAG_BITS'(1) : t + MEM_TAG_BITS'(1);
    endfunction

endpackage

// File: rtl/mem_resp_pipe.sv
// rtl/mem_resp_pipe.sv - fixed-depth shift register carrying in-flight load entries
module mem_resp_pipe
    import mem_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clock,
    input  logic      reset,
    input  inflight_t in_entry,
    output inflight_t out_entry
);

    inflight_t stages [DEPTH];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stages[i] <= '0;
            end
        end else begin
            stages[0] <= in_entry;
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign out_entry = stages[DEPTH-1];

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - fixed-latency tagged memory responder; MEM_RESP_STALL_EN adds LFSR-driven refusals
module mem_responder
    import mem_pkg::*;
#(
    parameter int MEM_LATENCY = 4,
    parameter int MEM_WORDS   = 1024
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [1:0]              proc2Imem_command,
    input  logic [63:0]             proc2Imem_addr,
    input  logic [63:0]             proc2Imem_data,
    output logic [MEM_TAG_BITS-1:0] Imem2proc_response,
    output logic [63:0]             Imem2proc_data,
    output logic [MEM_TAG_BITS-1:0] Imem2proc_tag
);

    localparam int IDX_BITS = $clog2(MEM_WORDS);

    logic [63:0]             mem [MEM_WORDS];
    logic [MEM_TAG_BITS-1:0] next_tag;
    logic [MEM_TAG_BITS-1:0] outstanding_count;
    logic [IDX_BITS-1:0]     idx;
    bus_command_e            cmd;
    logic                    stall;
    logic                    accept;
    logic                    load_accept;
    logic                    store_accept;
    inflight_t               in_entry;
    inflight_t               out_entry;
    logic                    addr_unused;

    assign cmd         = bus_command_e'(proc2Imem_command);
    assign idx         = proc2Imem_addr[IDX_BITS+2:3];
    assign addr_unused = ^{proc2Imem_addr[63:IDX_BITS+3], proc2Imem_addr[2:0]};

`ifdef MEM_RESP_STALL_EN
    logic [15:0] lfsr;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign stall = (lfsr[1:0] == 2'b00);
`else
    assign stall = 1'b0;
`endif

    // Acceptance looks only at the registered count; a completion this cycle does not free a slot early.
    assign accept = ((cmd == BUS_LOAD) || (cmd == BUS_STORE))
                  && (outstanding_count < MEM_TAG_BITS'(NUM_MEM_TAGS)) && !stall;
    assign load_accept  = accept && (cmd == BUS_LOAD);
    assign store_accept = accept && (cmd == BUS_STORE);

    assign Imem2proc_response = (reset && accept) ? next_tag : '0;

    always_comb begin
        in_entry       = '0;
        in_entry.valid = load_accept;
        in_entry.tag   = next_tag;
        if (load_accept) begin
            in_entry.data = mem[idx];
        end
    end

    mem_resp_pipe #(
        .DEPTH(MEM_LATENCY)
    ) u_pipe (
        .clock    (clock),
        .reset    (reset),
        .in_entry (in_entry),
        .out_entry(out_entry)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            next_tag          <= MEM_TAG_BITS'(1);
            outstanding_count <= '0;
            Imem2proc_tag     <= '0;
            Imem2proc_data    <= '0;
        end else begin
            if (accept) begin
                next_tag <= tag_incr(next_tag);
            end
            case ({load_accept, out_entry.valid})
                2'b10:   outstanding_count <= outstanding_count + MEM_TAG_BITS'(1);
                2'b01:   outstanding_count <= outstanding_count - MEM_TAG_BITS'(1);
                default: outstanding_count <= outstanding_count;
            endcase
            Imem2proc_tag  <= out_entry.valid ? out_entry.tag  : '0;
            Imem2proc_data <= out_entry.valid ? out_entry.data : '0;
        end
    end

    // Backing store keeps its contents through reset.
    always_ff @(posedge clock) begin
        if (store_accept) begin
            mem[idx] <= proc2Imem_data;
        end
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter MEM_LATENCY, default 4, meaning cycles from the acceptance edge to the data return edge (legal 1..32).
REQ-002 SHALL have parameter MEM_WORDS, default 1024, meaning the number of 64-bit words in the backing store (power of two).
REQ-003 SHALL have port clock  in  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset (asserted at 0).
REQ-005 SHALL have port proc2Imem_command  in  2  bus command: BUS_NONE=00, BUS_LOAD=01, BUS_STORE=10.
REQ-006 SHALL have port proc2Imem_addr  in  64  byte address; bits [2:0] ignored.
REQ-007 SHALL have port proc2Imem_data  in  64  store data.
REQ-008 SHALL have port Imem2proc_response  out  4  tag granted this cycle; 0 means refused or no request.
REQ-009 SHALL have port Imem2proc_data  out  64  load data, valid while Imem2proc_tag != 0.
REQ-010 SHALL have port Imem2proc_tag  out  4  tag of the completing load; 0 means none.

Function
REQ-011 Imem2proc_response SHALL be combinational from the command and registered state, in the same cycle as the command.
REQ-012 A LOAD or STORE SHALL be accepted when outstanding_count < 15 and no stall is active; otherwise response = 0 and the request has no effect.
REQ-013 Granted tags SHALL come from next_tag: start at 1, increment on each accepted request, wrap 15->1, never 0.
REQ-014 An accepted STORE SHALL write mem[addr[log2(MEM_WORDS)+2:3]] at that clock edge, SHALL consume a tag, and SHALL produce no data return.
REQ-015 An accepted LOAD SHALL read the word at acceptance and carry it with its tag.
REQ-016 Imem2proc_tag/Imem2proc_data SHALL present the load exactly MEM_LATENCY edges after the acceptance edge, for one cycle.
REQ-017 Completions SHALL be in acceptance order, with at most one per cycle, guaranteed by fixed latency.
REQ-018 Address bits above the index SHALL be ignored (aliasing).
REQ-019 A STORE accepted in the same cycle as an older LOAD to the same word SHALL NOT alter that load's returned data.
REQ-020 A LOAD accepted the cycle after a STORE to the same word SHALL return the stored data.
REQ-021 outstanding_count SHALL count accepted loads not yet completed.
  - Accept and completion in the same cycle leave the count unchanged.
  - Acceptance uses the registered count only; no same-cycle bypass.
REQ-022 Imem2proc_data SHALL be 0 whenever Imem2proc_tag == 0.

Reset
REQ-023 On reset low, asynchronously:
  - Imem2proc_tag = 0, Imem2proc_data = 0.
  - next_tag = 1, outstanding_count = 0.
  - All in-flight entries are cleared.
  - While reset is low, Imem2proc_response = 0.
REQ-024 Loads in flight when reset asserts SHALL never complete.
REQ-025 The backing store SHALL NOT be reset; its contents persist across reset.

Configuration
REQ-026 Macro MEM_RESP_STALL_EN SHALL enable pseudo-random refusal.
  - When defined: a 16-bit LFSR (seed 16'hACE1, reset to seed, stepping every cycle) forces response = 0 whenever LFSR[1:0] == 2'b00, independent of occupancy.
  - When undefined: the LFSR logic is absent and acceptance depends only on REQ-012.

Structure
REQ-027 Shared package mem_pkg SHALL hold:
  - the bus command enum (BUS_NONE/BUS_LOAD/BUS_STORE);
  - MEM_TAG_BITS = 4 and NUM_MEM_TAGS = 15;
  - the in-flight entry struct {valid, tag, data}.
REQ-028 Sub-module mem_resp_pipe SHALL implement the MEM_LATENCY-deep shift register of in-flight entries; mem_responder owns the array, tag allocation and count.

Verification
REQ-029 Reset and first load: reset low 2 cycles, then LOAD addr 0x40 with mem[8] = 0x1234 -> response 1 same cycle; after 4 edges tag = 1, data = 0x1234 for one cycle; then tag = 0, data = 0.
REQ-030 Store then load: STORE 0x18 data 0xCAFE, then LOAD 0x1F the next cycle -> responses 1, 2; tag 2 returns 0xCAFE; no return for tag 1.
REQ-031 Tag wrap and full (MEM_LATENCY = 20): 15 back-to-back loads -> tags 1..15; 16th -> response 0; the cycle after tag 1 completes, a LOAD gets tag 1.
REQ-032 Reset mid-flight: LOAD accepted, reset low 1 cycle after -> tag never returns; next load gets tag 1.
REQ-033 Stall (MEM_RESP_STALL_EN defined): LOAD held 64 cycles -> response 0 exactly on cycles where the LFSR[1:0] model is 00; granted tags still sequential.
REQ-034 Idle/aliasing: BUS_NONE -> response 0; LOAD at 0x2040 with MEM_WORDS = 1024 returns mem[8].
